// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command, ALU and response bundle for alu_cmd_driver; ALU_STATS_EN adds stat ports
interface alu_cmd_driver_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_result;
  logic             alu_overflow;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_overflow;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
`ifdef ALU_STATS_EN
  logic [7:0]       stat_ops;
  logic [7:0]       stat_ovf;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_overflow, alu_zero, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
           rsp_tag, busy, stat_ops, stat_ovf
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_overflow, alu_zero, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
           rsp_tag, busy, stat_ops, stat_ovf
  );
`else
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_overflow, alu_zero, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
           rsp_tag, busy
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_overflow, alu_zero, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_overflow, rsp_zero,
           rsp_tag, busy
  );
`endif
endinterface

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - queued command driver for a 4-bit combinational ALU with tagged responses
// Optional saturating response/overflow counters when ALU_STATS_EN is defined.
module alu_cmd_driver #(
  parameter int CMD_DEPTH     = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_driver_if.master  bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [2:0]       fifo_op  [CMD_DEPTH];
  logic [3:0]       fifo_a   [CMD_DEPTH];
  logic [3:0]       fifo_b   [CMD_DEPTH];
  logic [TAG_W-1:0] fifo_tag [CMD_DEPTH];

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [TAG_W-1:0] tag_cnt_q, tag_pend_q, rsp_tag_q;
  logic [2:0]       alu_op_q;
  logic [3:0]       alu_a_q, alu_b_q, rsp_result_q;
  logic             rsp_ovf_q, rsp_zero_q;
  logic             full, empty, push, pop, rsp_hs, capture;

  // cmd_ready comes from the registered count only, so a pop never frees a slot in the same cycle
  assign full    = (count_q == CW'(CMD_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.cmd_valid && !full;
  assign rsp_hs  = (state_q == S_RESP) && bus.rsp_ready;
  assign pop     = !empty && ((state_q == S_IDLE) || rsp_hs);
  assign capture = (state_q == S_EXEC) && (settle_q == '0);
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (pop) begin
      state_d  = S_EXEC;
      settle_d = SW'(SETTLE_CYCLES - 1);
    end else if (rsp_hs) begin
      state_d = S_IDLE;
    end else if (capture) begin
      state_d = S_RESP;
    end else if (state_q == S_EXEC) begin
      settle_d = settle_q - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_q]  <= bus.cmd_op;
      fifo_a[wr_ptr_q]   <= bus.cmd_a;
      fifo_b[wr_ptr_q]   <= bus.cmd_b;
      fifo_tag[wr_ptr_q] <= tag_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_cnt_q    <= '0;
      tag_pend_q   <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        tag_cnt_q <= tag_cnt_q + TAG_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        alu_op_q   <= fifo_op[rd_ptr_q];
        alu_a_q    <= fifo_a[rd_ptr_q];
        alu_b_q    <= fifo_b[rd_ptr_q];
        tag_pend_q <= fifo_tag[rd_ptr_q];
      end
      if (capture) begin
        rsp_result_q <= bus.alu_result;
        rsp_ovf_q    <= bus.alu_overflow;
        rsp_zero_q   <= bus.alu_zero;
        rsp_tag_q    <= tag_pend_q;
      end
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.busy         = (state_q != S_IDLE) || !empty;

`ifdef ALU_STATS_EN
  logic [7:0] stat_ops_q, stat_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != 8'hFF) stat_ops_q <= stat_ops_q + 8'd1;
      if (rsp_ovf_q && (stat_ovf_q != 8'hFF)) stat_ovf_q <= stat_ovf_q + 8'd1;
    end
  end

  assign bus.stat_ops = stat_ops_q;
  assign bus.stat_ovf = stat_ovf_q;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with an in-bench ALU and response scoreboard
module tb_alu_cmd_driver;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [3:0] res;
    logic       ovf;
    logic       zero;
    logic [3:0] tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_driver_if #(.TAG_W(TAG_W)) bus();

  alu_cmd_driver #(.CMD_DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   model_tag = 0;
  int   n_push = 0;
  int   n_rsp = 0;
  rsp_t exp_q[$];
  int   got_tags[$];
  logic stall_prev = 1'b0;
  rsp_t stall_val;

  // Signed 4-bit ALU: overflowing ADD/SUB yields result 0 with overflow set
  function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, s;
    logic [3:0] r;
    logic o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 0;
    r  = 4'h0;
    o  = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; if (s > 7 || s < -8) o = 1'b1; else r = 4'(s); end
      3'd1: begin s = sa - sb; if (s > 7 || s < -8) o = 1'b1; else r = 4'(s); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {r, o, (r == 4'h0)};
  endfunction

  always_comb {bus.alu_result, bus.alu_overflow, bus.alu_zero} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic rand_cmd();
    bus.cmd_op = 3'($urandom_range(0, 7));
    bus.cmd_a  = 4'($urandom_range(0, 15));
    bus.cmd_b  = 4'($urandom_range(0, 15));
  endtask

  // Called at posedge+1; samples mid-cycle, scores handshakes, returns at the next posedge+1
  task automatic step();
    rsp_t got;
    #4;
    got = {bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_tag};
    if (stall_prev && bus.rsp_valid) chk("rsp_stable", 32'(got), 32'(stall_val));
    stall_prev = bus.rsp_valid && !bus.rsp_ready;
    stall_val  = got;
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back({alu_ref(bus.cmd_op, bus.cmd_a, bus.cmd_b), 4'(model_tag)});
      model_tag = (model_tag + 1) % 16;
      n_push++;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      got_tags.push_back(int'(bus.rsp_tag));
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed=tag%0h expected=no_response", bus.rsp_tag);
      end
      if (exp_q.size() != 0) chk("rsp_fields", 32'(got), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_fields", 32'({bus.rsp_result, bus.rsp_overflow, bus.rsp_zero, bus.rsp_tag}), 0);
`ifdef ALU_STATS_EN
    chk("rst_stat_ops", 32'(bus.stat_ops), 0);
    chk("rst_stat_ovf", 32'(bus.stat_ovf), 0);
`endif
    exp_q.delete();
    got_tags.delete();
    model_tag  = 0;
    n_push     = 0;
    n_rsp      = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] er, input logic eo, input logic ez, input int etag);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk({name, "_valid_e0"}, 32'(bus.rsp_valid), 0);
    step();
    chk({name, "_valid_e1"}, 32'(bus.rsp_valid), 0);
    chk({name, "_alu_drive"}, 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({op, a, b}));
    step();
    chk({name, "_valid_e2"}, 32'(bus.rsp_valid), 1);
    chk({name, "_result"}, 32'(bus.rsp_result), 32'(er));
    chk({name, "_ovf_zero"}, 32'({bus.rsp_overflow, bus.rsp_zero}), 32'({eo, ez}));
    chk({name, "_tag"}, 32'(bus.rsp_tag), 32'(etag));
    step();
    chk({name, "_idle"}, 32'({bus.rsp_valid, bus.busy}), 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_alu_regs", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 0);
    do_reset();

    directed("add_3_4",  3'd0, 4'd3,    4'd4,    4'd7, 1'b0, 1'b0, 0);
    directed("add_7_1",  3'd0, 4'd7,    4'd1,    4'd0, 1'b1, 1'b1, 1);
    directed("sub_5_5",  3'd1, 4'd5,    4'd5,    4'd0, 1'b0, 1'b1, 2);
    directed("cmp",      3'd6, 4'b1110, 4'b0001, 4'd1, 1'b0, 1'b0, 3);
    directed("eq_9_9",   3'd7, 4'd9,    4'd9,    4'd1, 1'b0, 1'b0, 4);
    directed("not_0",    3'd2, 4'd0,    4'd0,    4'hF, 1'b0, 1'b0, 5);

    // Backpressure: capacity is four queued plus one in flight
    do_reset();
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_cmd();
      step();
    end
    chk("bp_accepted", 32'(n_push), 5);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("bp_busy", 32'(bus.busy), 1);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && n_rsp < 5; i++) step();
    chk("bp_responses", 32'(n_rsp), 5);
    for (int i = 0; i < 5 && i < got_tags.size(); i++) chk($sformatf("bp_tag%0d", i), 32'(got_tags[i]), 32'(i));

    // Tag wrap with random valid/ready
    do_reset();
    for (int i = 0; i < 3000 && n_rsp < 17; i++) begin
      rand_cmd();
      bus.cmd_valid = (n_push < 17) && ($urandom_range(0, 1) == 1);
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("wrap_responses", 32'(n_rsp), 17);
    if (got_tags.size() >= 17) begin
      chk("wrap_tag15", 32'(got_tags[15]), 15);
      chk("wrap_tag16", 32'(got_tags[16]), 0);
    end

    // Reset while in EXEC with three commands queued
    do_reset();
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_cmd();
      step();
    end
    bus.rsp_ready = 1'b1;
    rand_cmd();
    step();
    bus.cmd_valid = 1'b0;
    chk("mid_pushes", 32'(n_push), 5);
    chk("mid_exec_state", 32'({bus.rsp_valid, bus.busy}), 32'(2'b01));
    do_reset();
    directed("post_rst", 3'd0, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
